param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_pkg.sv | 14 +
 rtl/param_sync_fifo_if.sv | 31 +++
 rtl/param_sync_fifo_mem_dp.sv | 27 ++
 rtl/param_sync_fifo.sv | 118 +++++++++++
 tb/tb_param_sync_fifo.sv | 133 +++++++++++++
 5 files changed

// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and helpers for the param_sync_fifo slice.
// The package is named fifo_pkg and is imported by the interface, the storage
// sub-module and the top.
package fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    logic                     wr_en;
    logic [DATA_W-1:0]        data_in;
    logic                     rd_en;
    logic [DATA_W-1:0]        data_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo_mem_dp.sv
// fifo_mem_dp: DATA_W x DEPTH storage with one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store the incoming word at the write address when the write is accepted.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: synchronous FIFO with registered full/empty/almost flags,
// occupancy count and one-cycle overflow/underflow pulses.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through output; when it
// is undefined data_out is a registered copy of the last popped word.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CW-1:0]     w_count_nxt;
    logic [DATA_W-1:0] w_mem_rd_data;

    // Acceptance uses the registered flags, so a full FIFO never writes through
    // and an empty FIFO never reads through.
    assign w_wr_acc = bus.wr_en && !r_full;
    assign w_rd_acc = bus.rd_en && !r_empty;

    // Next occupancy: the flags are registered from this value.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers, count, flags and error pulses; reset overrides any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count     <= w_count_nxt;
            r_full      <= (int'(w_count_nxt) == DEPTH);
            r_empty     <= (w_count_nxt == '0);
            r_afull     <= (int'(w_count_nxt) >= AFULL_TH);
            r_aempty    <= (int'(w_count_nxt) <= AEMPTY_TH);
            r_overflow  <= bus.wr_en && r_full;
            r_underflow <= bus.rd_en && r_empty;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd_data)
    );

`ifdef FIFO_FWFT_EN
    // Head entry falls through combinationally; forced to zero while empty so
    // that reset and drained states present a clean value.
    assign bus.data_out = r_empty ? '0 : w_mem_rd_data;
`else
    logic [DATA_W-1:0] r_data_out_p1;

    // Capture the popped word on an accepted read; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out_p1 <= '0;
        end else if (w_rd_acc) begin
            r_data_out_p1 <= w_mem_rd_data;
        end
    end

    assign bus.data_out = r_data_out_p1;
`endif

    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DATA_W=16, DEPTH=16) with a queue
// scoreboard. Handles both the registered and the FIFO_FWFT_EN output modes.
module tb_param_sync_fifo;
    localparam int DW = 16;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    param_sync_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    param_sync_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DP),
        .AFULL_TH  (DP - 2),
        .AEMPTY_TH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every status output against the scoreboard state.
    task automatic chk_status(input bit exp_ovf, input bit exp_udf);
        int sz;
        sz = sb_q.size();
        chk("count",        32'(bus.count),        32'(sz));
        chk("full",         32'(bus.full),         32'(sz == DP));
        chk("empty",        32'(bus.empty),        32'(sz == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(sz >= DP - 2));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= 2));
        chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
        chk("underflow",    32'(bus.underflow),    32'(exp_udf));
    endtask

    // One clock of stimulus; the scoreboard predicts acceptance from its own size.
    task automatic step(input bit wr, input logic [DW-1:0] din, input bit rd);
        bit wacc, racc, ovf, udf;
        wacc = wr && (sb_q.size() < DP);
        racc = rd && (sb_q.size() > 0);
        ovf  = wr && (sb_q.size() == DP);
        udf  = rd && (sb_q.size() == 0);
        if (racc) last_data = sb_q.pop_front();
        if (wacc) sb_q.push_back(din);
        bus.wr_en   = wr;
        bus.data_in = din;
        bus.rd_en   = rd;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk_status(ovf, udf);
`ifdef FIFO_FWFT_EN
        chk("data_out_fwft", 32'(bus.data_out), (sb_q.size() > 0) ? 32'(sb_q[0]) : 32'(0));
`else
        chk("data_out", 32'(bus.data_out), 32'(last_data));
`endif
    endtask

    task automatic do_reset(input int cycles, input bit wr);
        rst         = 1'b1;
        bus.wr_en   = wr;
        bus.data_in = 16'hDEAD;
        bus.rd_en   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        sb_q.delete();
        last_data = '0;
        chk_status(1'b0, 1'b0);
        chk("data_out_rst", 32'(bus.data_out), 32'(0));
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        #1;

        // Reset held three cycles with a write pending: nothing is stored.
        do_reset(3, 1'b1);
        step(1'b0, 16'h0, 1'b0);

        // Fill with 3..18, then a rejected write of 19.
        for (int v = 3; v <= 18; v++) step(1'b1, DW'(v), 1'b0);
        step(1'b1, 16'd19, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        // Drain 16 words in order, then an extra read that underflows.
        for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);

        // Concurrent traffic at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'(16'h0200 + i), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);

        // Write and read together while full: read proceeds, write rejected.
        for (int i = 0; i < DP; i++) step(1'b1, DW'(16'h0300 + i), 1'b0);
        step(1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < DP - 1; i++) step(1'b0, 16'h0, 1'b1);

        // Write and read together while empty: write proceeds, read rejected.
        step(1'b1, 16'h0042, 1'b1);
        step(1'b0, 16'h0, 1'b1);

        // Reset in mid-operation at count 9, then a clean round trip.
        for (int i = 0; i < 9; i++) step(1'b1, DW'(16'h0400 + i), 1'b0);
        do_reset(1, 1'b0);
        step(1'b1, 16'hA5A5, 1'b0);
        step(1'b0, 16'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
